mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit_pkg.sv | 21 ++
 rtl/mem_access_unit_if.sv | 23 ++
 rtl/mem_access_unit_mem_wb.sv | 23 ++
 rtl/mem_access_unit.sv | 132 +++++++++++++
 tb/tb_mem_access_unit.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared pipeline types for the memory stage: FSM state, datapath widths, MEM/WB bundle.
// The WB mux reuses mem_wb_t so both sides of the MEM/WB register agree on layout.
package mem_access_unit_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] mem_data;
        logic [WORD_W-1:0] alu_res;
        logic [REG_W-1:0]  write_reg;
        logic              mem_to_reg;
        logic              reg_write;
    } mem_wb_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data-memory port: the memory stage is master, the memory is slave.
// Request fields are held stable by the master for as long as mem_req is high.
interface mem_access_unit_if;
    import mem_access_unit_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/mem_access_unit_mem_wb.sv
// MEM/WB pipeline register: captures d every cycle, or a zeroed bubble when bubble is set.
// Latency 1 cycle; no backpressure of its own, the owning FSM decides bubble vs capture.
module mem_wb_reg
    import mem_access_unit_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    bubble,
    input  mem_wb_t d,
    output mem_wb_t q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: turns EX/MEM load/store control into a req/ack transaction and owns MEM/WB.
// Latency 1 cycle for non-memory ops, 1+k cycles for an access acked in BUSY cycle k.
// Backpressure: stall holds the upstream pipeline while a request is launching or outstanding.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WORD_W-1:0]  alu_res,
    input  logic [WORD_W-1:0]  Rt_data,
    input  logic [REG_W-1:0]   write_reg,
    input  logic               MemWrite,
    input  logic               MemToReg,
    input  logic               RegWrite,
    input  logic               err_clr,
    mem_access_unit_if.master  mem,
    output logic               stall,
    output logic [WORD_W-1:0]  mem_data_out,
    output logic [WORD_W-1:0]  alu_res_out,
    output logic [REG_W-1:0]   write_reg_out,
    output logic               MemToReg_out,
    output logic               RegWrite_out,
    output logic               err_misaligned,
    output logic               err_timeout
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             access, aligned;
    logic             launch, set_mis, set_to, bubble;
    mem_wb_t          wb_d, wb_q;

    assign access  = MemWrite | MemToReg;
    assign aligned = (alu_res[1:0] == 2'b00);

    always_comb begin
        state_nxt         = state;
        stall             = 1'b0;
        launch            = 1'b0;
        set_mis           = 1'b0;
        set_to            = 1'b0;
        bubble            = 1'b0;
        wb_d              = '0;
        wb_d.alu_res      = alu_res;
        wb_d.write_reg    = write_reg;

        case (state)
            IDLE: begin
                if (access && aligned) begin
                    stall     = 1'b1;
                    launch    = 1'b1;
                    bubble    = 1'b1;
                    state_nxt = BUSY;
                end else if (access) begin
                    // misaligned access retires with its write-back suppressed
                    set_mis = 1'b1;
                end else begin
                    wb_d.reg_write = RegWrite;
                end
            end
            BUSY: begin
                if (mem.mem_ack) begin
                    wb_d.mem_data   = mem.mem_rdata;
                    wb_d.reg_write  = RegWrite;
                    wb_d.mem_to_reg = MemToReg;
                    state_nxt       = IDLE;
                end else if (cnt == LAST_CNT) begin
                    set_to    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // stall must read 0 the moment reset asserts, even with an access presented
        if (!reset) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            mem.mem_req    <= 1'b0;
            mem.mem_we     <= 1'b0;
            mem.mem_addr   <= '0;
            mem.mem_wdata  <= '0;
            err_misaligned <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                cnt           <= '0;
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= MemWrite;
                mem.mem_addr  <= alu_res;
                mem.mem_wdata <= Rt_data;
            end else if (state == BUSY) begin
                cnt <= cnt + 1'b1;
                if (state_nxt == IDLE) begin
                    mem.mem_req <= 1'b0;
                end
            end
            err_misaligned <= set_mis | (err_misaligned & ~err_clr);
            err_timeout    <= set_to  | (err_timeout & ~err_clr);
        end
    end

    mem_wb_reg u_mem_wb (
        .clk    (clk),
        .reset  (reset),
        .bubble (bubble),
        .d      (wb_d),
        .q      (wb_q)
    );

    assign mem_data_out  = wb_q.mem_data;
    assign alu_res_out   = wb_q.alu_res;
    assign write_reg_out = wb_q.write_reg;
    assign MemToReg_out  = wb_q.mem_to_reg;
    assign RegWrite_out  = wb_q.reg_write;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases then random instructions against a per-instruction model.
module tb_mem_access_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_res, Rt_data;
    logic [4:0]  write_reg;
    logic        MemWrite, MemToReg, RegWrite, err_clr;
    logic        stall;
    logic [31:0] mem_data_out, alu_res_out;
    logic [4:0]  write_reg_out;
    logic        MemToReg_out, RegWrite_out, err_misaligned, err_timeout;

    int n_cmp  = 0;
    int n_fail = 0;
    bit exp_mis = 0;
    bit exp_to  = 0;

    mem_access_unit_if mif ();

    mem_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .alu_res        (alu_res),
        .Rt_data        (Rt_data),
        .write_reg      (write_reg),
        .MemWrite       (MemWrite),
        .MemToReg       (MemToReg),
        .RegWrite       (RegWrite),
        .err_clr        (err_clr),
        .mem            (mif),
        .stall          (stall),
        .mem_data_out   (mem_data_out),
        .alu_res_out    (alu_res_out),
        .write_reg_out  (write_reg_out),
        .MemToReg_out   (MemToReg_out),
        .RegWrite_out   (RegWrite_out),
        .err_misaligned (err_misaligned),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mem_req"}, mif.mem_req, 0);
        chk({tag, ".stall"}, stall, 0);
        chk({tag, ".mem_data_out"}, mem_data_out, 0);
        chk({tag, ".alu_res_out"}, alu_res_out, 0);
        chk({tag, ".write_reg_out"}, write_reg_out, 0);
        chk({tag, ".MemToReg_out"}, MemToReg_out, 0);
        chk({tag, ".RegWrite_out"}, RegWrite_out, 0);
        chk({tag, ".err_misaligned"}, err_misaligned, 0);
        chk({tag, ".err_timeout"}, err_timeout, 0);
    endtask

    // One instruction held in EX/MEM until it retires. ack_k = BUSY cycle carrying mem_ack
    // (1-based); 0 or beyond TIMEOUT means the memory never answers. Called just after a posedge.
    task automatic run_instr(input string tag, input bit wr, input bit ld, input bit rw,
                             input logic [31:0] addr, input logic [31:0] data,
                             input logic [4:0] wreg, input int ack_k, input bit clr,
                             input logic [31:0] rdata);
        bit go, acked, timed_out, done;
        int exp_stall, nstall, c;
        go        = (wr | ld) && (addr[1:0] == 2'b00);
        acked     = go && ack_k >= 1 && ack_k <= TIMEOUT;
        timed_out = go && !acked;
        exp_stall = !go ? 0 : (acked ? ack_k : TIMEOUT);
        MemWrite  = wr;
        MemToReg  = ld;
        RegWrite  = rw;
        alu_res   = addr;
        Rt_data   = data;
        write_reg = wreg;
        err_clr   = clr;
        nstall    = 0;
        done      = 0;
        c         = 0;
        while (!done && c < 64) begin
            if (c == 0) begin
                mif.mem_ack   = 1'($urandom_range(0, 1));
                mif.mem_rdata = $urandom;
            end else begin
                mif.mem_ack   = (c == ack_k);
                mif.mem_rdata = (c == ack_k) ? rdata : $urandom;
            end
            @(negedge clk);
            if (c == 0) chk({tag, ".req_idle"}, mif.mem_req, 0);
            if (go && c == 1) begin
                chk({tag, ".mem_req"}, mif.mem_req, 1);
                chk({tag, ".mem_we"}, mif.mem_we, wr);
                chk({tag, ".mem_addr"}, mif.mem_addr, addr);
                chk({tag, ".mem_wdata"}, mif.mem_wdata, data);
            end else if (go && c > 1) begin
                if (mif.mem_req !== 1'b1 || mif.mem_we !== wr || mif.mem_addr !== addr ||
                    mif.mem_wdata !== data)
                    chk({tag, ".req_stable"}, {mif.mem_req, mif.mem_we, mif.mem_addr[29:0]},
                        {1'b1, wr, addr[29:0]});
            end
            if (stall === 1'b1) nstall++;
            else done = 1;
            @(posedge clk);
            #1;
            c++;
        end
        mif.mem_ack = 1'b0;
        err_clr     = 1'b0;
        if (!done) chk({tag, ".retire_bound"}, 0, 1);
        chk({tag, ".stall_cycles"}, nstall, exp_stall);
        chk({tag, ".req_after"}, mif.mem_req, 0);

        exp_mis = ((wr | ld) && addr[1:0] != 2'b00) | (exp_mis & ~clr);
        exp_to  = timed_out | (exp_to & ~clr);
        chk({tag, ".err_misaligned"}, err_misaligned, exp_mis);
        chk({tag, ".err_timeout"}, err_timeout, exp_to);

        if (timed_out) begin
            chk({tag, ".RegWrite_out"}, RegWrite_out, 0);
            chk({tag, ".mem_data_out"}, mem_data_out, 0);
        end else begin
            chk({tag, ".alu_res_out"}, alu_res_out, addr);
            chk({tag, ".write_reg_out"}, write_reg_out, wreg);
            chk({tag, ".RegWrite_out"}, RegWrite_out, (go || !(wr | ld)) ? rw : 1'b0);
            chk({tag, ".MemToReg_out"}, MemToReg_out, acked ? ld : 1'b0);
            if (acked) chk({tag, ".mem_data_out"}, mem_data_out, rdata);
        end
    endtask

    initial begin
        reset         = 1'b0;
        alu_res       = '0;
        Rt_data       = '0;
        write_reg     = '0;
        MemWrite      = 1'b0;
        MemToReg      = 1'b0;
        RegWrite      = 1'b0;
        err_clr       = 1'b0;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;
        #12;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_instr("alu", 0, 0, 1, 32'h1234, 32'h0, 5'd5, 0, 0, 32'h0);
        run_instr("load_ack1", 0, 1, 1, 32'h100, 32'h0, 5'd7, 1, 0, 32'hDEADBEEF);
        run_instr("store_ack3", 1, 0, 0, 32'h40, 32'hA5A5A5A5, 5'd3, 3, 0, 32'h0);
        run_instr("load_misaligned", 0, 1, 1, 32'h103, 32'h0, 5'd9, 1, 0, 32'h0);
        run_instr("alu_errclr", 0, 0, 1, 32'h55, 32'h0, 5'd2, 0, 1, 32'h0);
        run_instr("load_timeout", 0, 1, 1, 32'h200, 32'h0, 5'd4, 0, 0, 32'h0);
        run_instr("load_ack_at_limit", 0, 1, 1, 32'h204, 32'h0, 5'd6, TIMEOUT, 0, 32'h0BADF00D);
        run_instr("misaligned_and_clr", 1, 0, 0, 32'h302, 32'h77, 5'd1, 0, 1, 32'h0);

        for (int i = 0; i < 40; i++) begin
            int          kind;
            logic [31:0] a;
            kind = int'($urandom_range(0, 3));
            a    = $urandom & 32'hFFFF_FFFC;
            if (kind == 3) a = a | 32'($urandom_range(1, 3));
            run_instr("rand",
                      kind == 2 || (kind == 3 && $urandom_range(0, 1) == 1),
                      kind == 1 || kind == 3,
                      kind == 1 || (kind == 0 && $urandom_range(0, 1) == 1),
                      a, $urandom, 5'($urandom_range(0, 31)),
                      int'($urandom_range(0, TIMEOUT + 2)),
                      $urandom_range(0, 3) == 0, $urandom);
        end

        // leave a sticky flag set so the asynchronous reset has something to clear
        run_instr("pre_reset_mis", 0, 1, 1, 32'h401, 32'h0, 5'd8, 0, 0, 32'h0);
        MemToReg  = 1'b1;
        RegWrite  = 1'b1;
        alu_res   = 32'h500;
        write_reg = 5'd10;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_busy.mem_req_before", mif.mem_req, 1);
        reset = 1'b0;
        #1;
        chk_all_zero("rst_busy");
        MemToReg  = 1'b0;
        RegWrite  = 1'b0;
        @(posedge clk);
        #1;
        reset       = 1'b1;
        mif.mem_ack = 1'b1;
        @(negedge clk);
        chk("rst_late_ack.stall", stall, 0);
        @(posedge clk);
        #1;
        chk("rst_late_ack.mem_req", mif.mem_req, 0);
        mif.mem_ack = 1'b0;
        exp_mis = 0;
        exp_to  = 0;
        run_instr("alu_after_reset", 0, 0, 1, 32'hCAFE, 32'h0, 5'd12, 0, 0, 32'h0);
        run_instr("load_after_reset", 0, 1, 1, 32'h600, 32'h0, 5'd13, 2, 0, 32'h12345678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
